// File: rtl/mem_port_arbiter.sv
// Arbitrates the core's fetch and data ports onto one single-ported memory bus,
// stalling the pipeline until every requested access has completed or timed out.
module mem_port_arbiter #(
   parameter int unsigned TIMEOUT = 255
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        inst_ren,
   input  logic [31:0] inst_addr,
   output logic [31:0] inst_data,
   input  logic        mem_ren,
   input  logic        mem_wen,
   input  logic [31:0] mem_addr,
   input  logic [31:0] mem_dout,
   output logic [31:0] mem_din,
   output logic        stall,
   output logic        bus_req,
   output logic        bus_we,
   output logic [31:0] bus_addr,
   output logic [31:0] bus_wdata,
   input  logic        bus_ack,
   input  logic [31:0] bus_rdata,
   output logic        bus_err
);

   typedef enum logic [1:0] {IDLE, DATA, INST} state_t;

   localparam logic [15:0] CNT_LAST = 16'(TIMEOUT - 1);

   state_t      state_q, state_d;
   logic        inst_done_q, inst_done_d;
   logic        data_done_q, data_done_d;
   logic [15:0] cnt_q, cnt_d;
   logic        bus_req_q, bus_req_d;
   logic        bus_we_q, bus_we_d;
   logic [31:0] bus_addr_q, bus_addr_d;
   logic [31:0] bus_wdata_q, bus_wdata_d;
   logic [31:0] inst_data_q, inst_data_d;
   logic [31:0] mem_din_q, mem_din_d;
   logic        bus_err_q, bus_err_d;

   logic        data_req;
   logic        timed_out;
   logic [31:0] rdata;

   assign data_req  = mem_ren | mem_wen;
   assign stall     = (inst_ren & ~inst_done_q) | (data_req & ~data_done_q);
   assign timed_out = (cnt_q == CNT_LAST);
   // A timed-out access completes as if the memory returned zero.
   assign rdata     = bus_ack ? bus_rdata : 32'h0000_0000;

   // NOTE: every signal gets a default first, so no path can infer a latch.
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      bus_req_d   = bus_req_q;
      bus_we_d    = bus_we_q;
      bus_addr_d  = bus_addr_q;
      bus_wdata_d = bus_wdata_q;
      inst_data_d = inst_data_q;
      mem_din_d   = mem_din_q;
      bus_err_d   = 1'b0;
      // The core advances on every non-stall edge, so both flags retire there.
      inst_done_d = stall ? inst_done_q : 1'b0;
      data_done_d = stall ? data_done_q : 1'b0;

      case (state_q)
         IDLE: begin
            cnt_d     = 16'd0;
            bus_req_d = 1'b0;
            // Data goes first: it belongs to the older instruction in MEM.
            if (data_req && !data_done_q) begin
               bus_addr_d  = mem_addr;
               bus_wdata_d = mem_dout;
               bus_we_d    = mem_wen;
               bus_req_d   = 1'b1;
               state_d     = DATA;
            end else if (inst_ren && !inst_done_q) begin
               bus_addr_d = inst_addr;
               bus_we_d   = 1'b0;
               bus_req_d  = 1'b1;
               state_d    = INST;
            end
         end
         DATA, INST: begin
            if (bus_ack || timed_out) begin
               if (state_q == DATA) begin
                  if (!bus_we_q) mem_din_d = rdata;
                  data_done_d = 1'b1;
               end else begin
                  inst_data_d = rdata;
                  inst_done_d = 1'b1;
               end
               bus_err_d = ~bus_ack;
               bus_req_d = 1'b0;
               cnt_d     = 16'd0;
               state_d   = IDLE;
            end else begin
               cnt_d = cnt_q + 16'd1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments only; the data
   // registers are reset too because they are visible outputs.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= IDLE;
         inst_done_q <= 1'b0;
         data_done_q <= 1'b0;
         cnt_q       <= 16'd0;
         bus_req_q   <= 1'b0;
         bus_we_q    <= 1'b0;
         bus_addr_q  <= 32'h0;
         bus_wdata_q <= 32'h0;
         inst_data_q <= 32'h0;
         mem_din_q   <= 32'h0;
         bus_err_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         inst_done_q <= inst_done_d;
         data_done_q <= data_done_d;
         cnt_q       <= cnt_d;
         bus_req_q   <= bus_req_d;
         bus_we_q    <= bus_we_d;
         bus_addr_q  <= bus_addr_d;
         bus_wdata_q <= bus_wdata_d;
         inst_data_q <= inst_data_d;
         mem_din_q   <= mem_din_d;
         bus_err_q   <= bus_err_d;
      end
   end

   assign bus_req   = bus_req_q;
   assign bus_we    = bus_we_q;
   assign bus_addr  = bus_addr_q;
   assign bus_wdata = bus_wdata_q;
   assign inst_data = inst_data_q;
   assign mem_din   = mem_din_q;
   assign bus_err   = bus_err_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized bench for mem_port_arbiter: a transaction-level model predicts bus order,
// stall length, timeouts and returned data for each pipeline step.
module tb_mem_port_arbiter;

   localparam int T = 4;

   logic        clk;
   logic        rst;
   logic        inst_ren;
   logic [31:0] inst_addr;
   logic [31:0] inst_data;
   logic        mem_ren;
   logic        mem_wen;
   logic [31:0] mem_addr;
   logic [31:0] mem_dout;
   logic [31:0] mem_din;
   logic        stall;
   logic        bus_req;
   logic        bus_we;
   logic [31:0] bus_addr;
   logic [31:0] bus_wdata;
   logic        bus_ack;
   logic [31:0] bus_rdata;
   logic        bus_err;

   mem_port_arbiter #(.TIMEOUT(T)) dut (
      .clk       (clk),
      .rst       (rst),
      .inst_ren  (inst_ren),
      .inst_addr (inst_addr),
      .inst_data (inst_data),
      .mem_ren   (mem_ren),
      .mem_wen   (mem_wen),
      .mem_addr  (mem_addr),
      .mem_dout  (mem_dout),
      .mem_din   (mem_din),
      .stall     (stall),
      .bus_req   (bus_req),
      .bus_we    (bus_we),
      .bus_addr  (bus_addr),
      .bus_wdata (bus_wdata),
      .bus_ack   (bus_ack),
      .bus_rdata (bus_rdata),
      .bus_err   (bus_err)
   );

   typedef struct {
      logic [31:0] addr;
      logic        we;
      logic [31:0] wdata;
      int          lat;
      logic [31:0] rdata;
   } txn_t;

   txn_t        txq[$];
   int          n_cmp = 0;
   int          n_err = 0;
   logic [31:0] exp_inst = 32'h0;
   logic [31:0] exp_din  = 32'h0;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Memory responder: acks each bus transaction after its planned latency and
   // checks that the issued access is the next one the model expects.
   bit   in_txn = 0;
   int   lat_cnt = 0;
   txn_t cur;
   always @(negedge clk) begin
      if (bus_req) begin
         if (!in_txn) begin
            in_txn  = 1;
            lat_cnt = 0;
            if (txq.size() == 0) begin
               check("pending_txn", 32'(txq.size()), 32'd1);
               cur.lat = 0;
               cur.rdata = 32'h0;
            end else begin
               cur = txq.pop_front();
               check("bus_addr", bus_addr, cur.addr);
               check("bus_we", {31'h0, bus_we}, {31'h0, cur.we});
               if (cur.we) check("bus_wdata", bus_wdata, cur.wdata);
            end
         end
         bus_ack   = (lat_cnt == cur.lat);
         bus_rdata = bus_ack ? cur.rdata : $urandom;
         lat_cnt++;
      end else begin
         in_txn  = 0;
         bus_ack = 1'b0;
      end
   end

   function automatic int cost(input int lat);
      return (lat < T) ? lat + 2 : T + 1;
   endfunction

   task automatic wait_release(output int st, output int er);
      bit released = 0;
      st = 0;
      er = 0;
      for (int i = 0; i < 200 && !released; i++) begin
         @(negedge clk);
         er += int'(bus_err);
         if (!stall) released = 1;
         else st++;
      end
      if (!released) check("stall_release", {31'h0, stall}, 32'h0);
   endtask

   task automatic do_step(input logic ir, input logic [31:0] ia, input logic mr, input logic mw,
                          input logic [31:0] ma, input logic [31:0] md, input int ilat, input int dlat);
      int   exp_st = 0;
      int   exp_er = 0;
      int   st, er;
      txn_t t;
      if (mr || mw) begin
         t.addr = ma; t.we = mw; t.wdata = md; t.lat = dlat; t.rdata = $urandom;
         txq.push_back(t);
         exp_st += cost(dlat);
         if (dlat >= T) exp_er++;
         if (!mw) exp_din = (dlat < T) ? t.rdata : 32'h0;
      end
      if (ir) begin
         t.addr = ia; t.we = 1'b0; t.wdata = 32'h0; t.lat = ilat; t.rdata = $urandom;
         txq.push_back(t);
         exp_st += cost(ilat);
         if (ilat >= T) exp_er++;
         exp_inst = (ilat < T) ? t.rdata : 32'h0;
      end
      @(posedge clk);
      #1;
      inst_ren = ir; inst_addr = ia; mem_ren = mr; mem_wen = mw; mem_addr = ma; mem_dout = md;
      wait_release(st, er);
      check("stall_cycles", 32'(st), 32'(exp_st));
      check("bus_err_count", 32'(er), 32'(exp_er));
      check("inst_data", inst_data, exp_inst);
      check("mem_din", mem_din, exp_din);
      check("txq_drained", 32'(txq.size()), 32'd0);
   endtask

   initial begin
      int   st, er;
      txn_t t;
      rst = 1'b0;
      inst_ren = 0; inst_addr = 0; mem_ren = 0; mem_wen = 0; mem_addr = 0; mem_dout = 0;
      bus_ack = 0; bus_rdata = 0;
      #12;
      check("rst_bus_req", {31'h0, bus_req}, 32'h0);
      check("rst_bus_addr", bus_addr, 32'h0);
      check("rst_inst_data", inst_data, 32'h0);
      check("rst_mem_din", mem_din, 32'h0);
      check("rst_stall", {31'h0, stall}, 32'h0);
      #10 rst = 1'b1;

      // Directed scenarios.
      do_step(1, 32'h100, 0, 0, 32'h0, 32'h0, 0, 0);           // fetch only
      do_step(1, 32'h104, 1, 0, 32'h200, 32'h0, 0, 0);         // load + fetch
      do_step(0, 32'h0, 1, 1, 32'h300, 32'hCAFE_F00D, 0, 3);   // store, ack latency 3
      do_step(1, 32'h108, 0, 0, 32'h0, 32'h0, 9, 0);           // fetch timeout
      do_step(0, 32'h0, 1, 0, 32'h204, 32'h0, 0, T - 1);       // ack on the last allowed cycle
      for (int i = 0; i < 4; i++)                              // back-to-back fetches
         do_step(1, 32'h10C + 32'(4 * i), 0, 0, 32'h0, 32'h0, 0, 0);

      // Reset while a data access is on the bus.
      t.addr = 32'h400; t.we = 1'b0; t.wdata = 32'h0; t.lat = 9; t.rdata = 32'h1234_5678;
      txq.push_back(t);
      @(posedge clk);
      #1;
      inst_ren = 0; mem_ren = 1; mem_wen = 0; mem_addr = 32'h400;
      @(negedge clk);
      @(negedge clk);
      #2 rst = 1'b0;
      #1;
      check("mid_rst_bus_req", {31'h0, bus_req}, 32'h0);
      check("mid_rst_bus_addr", bus_addr, 32'h0);
      check("mid_rst_mem_din", mem_din, 32'h0);
      check("mid_rst_inst_data", inst_data, 32'h0);
      check("mid_rst_stall", {31'h0, stall}, 32'h1);
      exp_din = 32'h0;
      exp_inst = 32'h0;
      @(negedge clk);
      t.lat = 1; t.rdata = $urandom;
      txq.push_back(t);
      exp_din = t.rdata;
      #2 rst = 1'b1;
      wait_release(st, er);
      check("reissue_stall_cycles", 32'(st), 32'd2);
      check("reissue_mem_din", mem_din, exp_din);
      check("reissue_drained", 32'(txq.size()), 32'd0);

      // Randomized pipeline steps.
      for (int i = 0; i < 150; i++) begin
         logic        ir, mr, mw;
         ir = 1'($urandom_range(0, 1));
         mr = 1'($urandom_range(0, 1));
         mw = ($urandom_range(0, 3) == 0);
         do_step(ir, {$urandom_range(0, 32'h3FFF), 2'b00}, mr, mw,
                 {$urandom_range(0, 32'h3FFF), 2'b00}, $urandom,
                 int'($urandom_range(0, T + 1)), int'($urandom_range(0, T + 1)));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
